// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: command handshake, open-collector line
// enables, raw line levels and the completion/error pulses.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       rx_inhibit;
   logic       tx_done;
   logic       tx_error;
   logic       err_nack;

   // Command source and the physical line side
   modport master (
      output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
      input  tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit,
             tx_done, tx_error, err_nack
   );

   // The transmitter itself
   modport slave (
      input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
      output tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit,
             tx_done, tx_error, err_nack
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a
// request-to-send, then shifts one command byte (LSB first, odd parity,
// stop) out on device-generated clock falls and checks the device ack.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int RTS_CYCLES     = 200,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input logic          clk,
   input logic          rst,
   ps2_host_tx_if.slave bus
);

   localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
                       ? ((TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES)
                       : ((INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES);
   localparam int TW = $clog2(MAXC + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);

   localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] RTS_LAST  = TW'(RTS_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          clkOe_q, clkOe_d;
   logic          dataOe_q, dataOe_d;
   logic          txReady_q, txReady_d;
   logic          txDone_q, txDone_d;
   logic          txError_q, txError_d;
   logic          errNack_q, errNack_d;

   logic [1:0]    clkSync_q, dataSync_q;
   logic [FW-1:0] clkFiltCnt_q, dataFiltCnt_q;
   logic          clkFilt_q, dataFilt_q, clkFiltPrev_q;
   logic          fallEdge;

   // Clock line: resynchronise, then only follow a new level once it has
   // been seen FILTER_LEN samples in a row so short glitches never count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clkSync_q     <= 2'b11;
         clkFilt_q     <= 1'b1;
         clkFiltPrev_q <= 1'b1;
         clkFiltCnt_q  <= '0;
      end else begin
         clkSync_q     <= {clkSync_q[0], bus.ps2_clk_in};
         clkFiltPrev_q <= clkFilt_q;
         if (clkSync_q[1] == clkFilt_q) begin
            clkFiltCnt_q <= '0;
         end else if (clkFiltCnt_q == FILT_LAST) begin
            clkFilt_q    <= clkSync_q[1];
            clkFiltCnt_q <= '0;
         end else begin
            clkFiltCnt_q <= clkFiltCnt_q + 1'b1;
         end
      end
   end

   // Data line gets the same synchroniser and persistence filter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dataSync_q    <= 2'b11;
         dataFilt_q    <= 1'b1;
         dataFiltCnt_q <= '0;
      end else begin
         dataSync_q <= {dataSync_q[0], bus.ps2_data_in};
         if (dataSync_q[1] == dataFilt_q) begin
            dataFiltCnt_q <= '0;
         end else if (dataFiltCnt_q == FILT_LAST) begin
            dataFilt_q    <= dataSync_q[1];
            dataFiltCnt_q <= '0;
         end else begin
            dataFiltCnt_q <= dataFiltCnt_q + 1'b1;
         end
      end
   end

   assign fallEdge = clkFiltPrev_q & ~clkFilt_q;

   // Frame sequencing: next state, line enables and result pulses.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bitCnt_d  = bitCnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      clkOe_d   = clkOe_q;
      dataOe_d  = dataOe_q;
      txDone_d  = 1'b0;
      txError_d = 1'b0;
      errNack_d = errNack_q;
      case (state_q)
         IDLE: begin
            clkOe_d  = 1'b0;
            dataOe_d = 1'b0;
            timer_d  = '0;
            bitCnt_d = '0;
            if (bus.tx_valid && txReady_q) begin
               shift_d  = bus.tx_data;
               parity_d = ~^bus.tx_data;
               clkOe_d  = 1'b1;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (timer_q == INH_LAST) begin
               timer_d  = '0;
               dataOe_d = 1'b1;
               state_d  = RTS;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         RTS: begin
            if (timer_q == RTS_LAST) begin
               timer_d  = '0;
               bitCnt_d = '0;
               clkOe_d  = 1'b0;
               state_d  = SEND;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         SEND, WAIT_ACK, WAIT_IDLE: begin
            if (timer_q == TO_LAST) begin
               timer_d   = '0;
               clkOe_d   = 1'b0;
               dataOe_d  = 1'b0;
               txError_d = 1'b1;
               errNack_d = 1'b0;
               state_d   = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
               if (state_q == SEND) begin
                  if (fallEdge) begin
                     bitCnt_d = bitCnt_q + 4'd1;
                     if (bitCnt_q < 4'd8) begin
                        dataOe_d = ~shift_q[bitCnt_q[2:0]];
                     end else if (bitCnt_q == 4'd8) begin
                        dataOe_d = ~parity_q;
                     end else begin
                        dataOe_d = 1'b0;
                        state_d  = WAIT_ACK;
                     end
                  end
               end else if (state_q == WAIT_ACK) begin
                  if (fallEdge) begin
                     if (!dataFilt_q) begin
                        state_d = WAIT_IDLE;
                     end else begin
                        txError_d = 1'b1;
                        errNack_d = 1'b1;
                        state_d   = IDLE;
                     end
                  end
               end else begin
                  if (clkFilt_q && dataFilt_q) begin
                     txDone_d = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      txReady_d = (state_d == IDLE);
   end

   // State and output registers; reset drops both lines immediately.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         clkOe_q   <= 1'b0;
         dataOe_q  <= 1'b0;
         txReady_q <= 1'b0;
         txDone_q  <= 1'b0;
         txError_q <= 1'b0;
         errNack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         clkOe_q   <= clkOe_d;
         dataOe_q  <= dataOe_d;
         txReady_q <= txReady_d;
         txDone_q  <= txDone_d;
         txError_q <= txError_d;
         errNack_q <= errNack_d;
      end
   end

   assign bus.tx_ready    = txReady_q;
   assign bus.ps2_clk_oe  = clkOe_q;
   assign bus.ps2_data_oe = dataOe_q;
   assign bus.rx_inhibit  = (state_q != IDLE);
   assign bus.tx_done     = txDone_q;
   assign bus.tx_error    = txError_q;
   assign bus.err_nack    = errNack_q;

endmodule
